// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM command arbiter: command encodings,
// one-hot FSM states, source selects and default bus widths.
package sdram_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int BANK_W_DEF = 2;

  // SDRAM commands as {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;

  typedef enum logic [4:0] {
    S_INIT  = 5'b00001,
    S_ARBIT = 5'b00010,
    S_AREF  = 5'b00100,
    S_WRITE = 5'b01000,
    S_READ  = 5'b10000
  } state_e;

  typedef enum logic [2:0] {
    SRC_NOP  = 3'd0,
    SRC_INIT = 3'd1,
    SRC_REF  = 3'd2,
    SRC_WR   = 3'd3,
    SRC_RD   = 3'd4
  } src_e;

  // Which stage owns the command bus in a given state
  function automatic src_e state_to_src(input state_e s);
    src_e r;
    case (s)
      S_INIT:  r = SRC_INIT;
      S_AREF:  r = SRC_REF;
      S_WRITE: r = SRC_WR;
      S_READ:  r = SRC_RD;
      S_ARBIT: r = SRC_NOP;
      default: r = SRC_NOP;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sdram_cmd_mux.sv
// Combinational source select for the SDRAM command/address/bank bus.
// Init and refresh have no bank of their own, so they drive bank 0.
module sdram_cmd_mux
  import sdram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BANK_W = BANK_W_DEF
) (
  input  src_e              sel,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [3:0]        ref_cmd,
  input  logic [ADDR_W-1:0] ref_addr,
  input  logic [3:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BANK_W-1:0] rd_bank,
  output logic [3:0]        cmd_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [BANK_W-1:0] bank_o
);

  // Route the selected stage onto the bus, NOP when nobody owns it
  always_comb begin
    cmd_o  = CMD_NOP;
    addr_o = {ADDR_W{1'b0}};
    bank_o = {BANK_W{1'b0}};
    case (sel)
      SRC_INIT: begin
        cmd_o  = init_cmd;
        addr_o = init_addr;
      end
      SRC_REF: begin
        cmd_o  = ref_cmd;
        addr_o = ref_addr;
      end
      SRC_WR: begin
        cmd_o  = wr_cmd;
        addr_o = wr_addr;
        bank_o = wr_bank;
      end
      SRC_RD: begin
        cmd_o  = rd_cmd;
        addr_o = rd_addr;
        bank_o = rd_bank;
      end
      SRC_NOP: begin
        cmd_o  = CMD_NOP;
        addr_o = {ADDR_W{1'b0}};
        bank_o = {BANK_W{1'b0}};
      end
      default: begin
        cmd_o  = CMD_NOP;
        addr_o = {ADDR_W{1'b0}};
        bank_o = {BANK_W{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: grants the command bus to init, refresh, write or
// read. Refresh has priority; write and read alternate on a tie. All pins
// and grant pulses are registered.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int BANK_W = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flag_init_end,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              ref_req,
  input  logic              flag_ref_end,
  input  logic [3:0]        ref_cmd,
  input  logic [ADDR_W-1:0] ref_addr,
  input  logic              wr_req,
  input  logic              flag_wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic              rd_req,
  input  logic              flag_rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BANK_W-1:0] rd_bank,
  output logic              ref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BANK_W-1:0] sdram_bank,
  output logic [ADDR_W-1:0] sdram_addr
);

  state_e            state_q, state_d;
  logic              last_wr_q, last_wr_d;
  logic              ref_en_q, ref_en_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              cke_q, cke_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BANK_W-1:0] bank_q, bank_d;

  // The bus source follows the current owner; the pins lag it by one cycle
  sdram_cmd_mux #(
    .ADDR_W (ADDR_W),
    .BANK_W (BANK_W)
  ) u_cmd_mux (
    .sel       (state_to_src(state_q)),
    .init_cmd  (init_cmd),
    .init_addr (init_addr),
    .ref_cmd   (ref_cmd),
    .ref_addr  (ref_addr),
    .wr_cmd    (wr_cmd),
    .wr_addr   (wr_addr),
    .wr_bank   (wr_bank),
    .rd_cmd    (rd_cmd),
    .rd_addr   (rd_addr),
    .rd_bank   (rd_bank),
    .cmd_o     (cmd_d),
    .addr_o    (addr_d),
    .bank_o    (bank_d)
  );

  // Next state, tie-break memory and one-cycle grant pulses on state entry
  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    ref_en_d  = 1'b0;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    cke_d     = 1'b1;
    case (state_q)
      S_INIT: begin
        if (flag_init_end) begin
          state_d = S_ARBIT;
        end else begin
          state_d = S_INIT;
        end
      end
      S_ARBIT: begin
        if (ref_req) begin
          state_d  = S_AREF;
          ref_en_d = 1'b1;
        end else if (wr_req && (!rd_req || !last_wr_q)) begin
          // write alone, or a tie where read was served last
          state_d   = S_WRITE;
          wr_en_d   = 1'b1;
          last_wr_d = 1'b1;
        end else if (rd_req) begin
          state_d   = S_READ;
          rd_en_d   = 1'b1;
          last_wr_d = 1'b0;
        end else begin
          state_d = S_ARBIT;
        end
      end
      S_AREF: begin
        if (flag_ref_end) begin
          state_d = S_ARBIT;
        end else begin
          state_d = S_AREF;
        end
      end
      S_WRITE: begin
        if (flag_wr_end) begin
          state_d = S_ARBIT;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_READ: begin
        if (flag_rd_end) begin
          state_d = S_ARBIT;
        end else begin
          state_d = S_READ;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // FSM state and tie-break register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_INIT;
      last_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
    end
  end

  // Registered grant pulses and SDRAM pins
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ref_en_q <= 1'b0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      cke_q    <= 1'b0;
      cmd_q    <= CMD_NOP;
      addr_q   <= {ADDR_W{1'b0}};
      bank_q   <= {BANK_W{1'b0}};
    end else begin
      ref_en_q <= ref_en_d;
      wr_en_q  <= wr_en_d;
      rd_en_q  <= rd_en_d;
      cke_q    <= cke_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      bank_q   <= bank_d;
    end
  end

  assign ref_en      = ref_en_q;
  assign wr_en       = wr_en_q;
  assign rd_en       = rd_en_q;
  assign sdram_cke   = cke_q;
  assign sdram_cs_n  = cmd_q[3];
  assign sdram_ras_n = cmd_q[2];
  assign sdram_cas_n = cmd_q[1];
  assign sdram_we_n  = cmd_q[0];
  assign sdram_bank  = bank_q;
  assign sdram_addr  = addr_q;

endmodule

// File: doc/sdram_arbit.md
# sdram_arbit

Command arbiter for the SDRAM controller. It sits directly downstream of the init, auto-refresh, write and read stages and grants the single SDRAM command/address bus to one of them at a time. Priority is refresh first, then write and read, which alternate. It drives the registered SDRAM pins (CKE, CS_n, RAS_n, CAS_n, WE_n, BA, A) and returns one-cycle enable pulses to the requesting stages.

## Interface
Parameters:
- ADDR_W, 12, SDRAM address bus width
- BANK_W, 2, bank address width

Ports:
- CLK  in  1  controller clock; all logic on the rising edge
- RST  in  1  asynchronous, active-high reset
- flag_init_end  in  1  init sequence complete; level, stays high once set
- init_cmd  in  4  {cs_n,ras_n,cas_n,we_n} from the init stage
- init_addr  in  ADDR_W  init stage address
- ref_req  in  1  refresh request (level)
- flag_ref_end  in  1  refresh stage finished (1-cycle pulse)
- ref_cmd  in  4  refresh stage command
- ref_addr  in  ADDR_W  refresh stage address
- wr_req  in  1  write stage request (level)
- flag_wr_end  in  1  write stage released the bus (1-cycle pulse)
- wr_cmd  in  4  write stage command
- wr_addr  in  ADDR_W  write stage address
- wr_bank  in  BANK_W  write stage bank
- rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank: same widths and meanings as the write set, for the read stage
- ref_en, wr_en, rd_en  out  1 each  grant pulses
- sdram_cke  out  1  clock enable
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins
- sdram_bank  out  BANK_W  bank pins
- sdram_addr  out  ADDR_W  address pins

## Operation
- States: S_INIT, S_ARBIT, S_AREF, S_WRITE, S_READ. One-hot, 5 bits.
- S_INIT: exit to S_ARBIT when flag_init_end = 1.
- S_ARBIT, decided every cycle:
  - If ref_req, go to S_AREF.
  - Else if wr_req and rd_req are both high, grant the stage not served last, using the last_wr register.
  - Else if only wr_req is high, go to S_WRITE.
  - Else if only rd_req is high, go to S_READ.
  - Else stay in S_ARBIT.
- last_wr: set to 1 on entry to S_WRITE, cleared on entry to S_READ. Reset value 0, so write wins the first tie.
- S_AREF exits to S_ARBIT on flag_ref_end. S_WRITE exits on flag_wr_end. S_READ exits on flag_rd_end. Requests are not sampled in the exit cycle.
- Source selection: S_INIT selects init_*; S_AREF selects ref_*; S_WRITE selects wr_*; S_READ selects rd_*; S_ARBIT drives NOP (4'b0111) with addr 0.
- Bank for init and refresh is 0.
- The cmd/addr/bank path is registered.

## Timing
- Reset values:
  - state S_INIT, last_wr 0
  - all *_en 0, sdram_cke 0
  - command pins 4'b0111 (NOP)
  - sdram_bank 0, sdram_addr 0
- sdram_cke goes to 1 on the first clock after RST deasserts and stays 1.
- Grant: ARBIT decision at edge N enters the state; the matching *_en is high for exactly cycle N..N+1 (registered, one pulse per entry).
- Pin latency: source cmd/addr/bank sampled in cycle k appear on the pins in cycle k+1.
- The exit-cycle command (e.g. PRE coinciding with flag_wr_end) is still forwarded.
- After the return to S_ARBIT, pins show NOP.
- ref_req raised during S_WRITE/S_READ is not preempted by the arbiter. The owning stage releases the bus (flag_*_end) and ref wins the next S_ARBIT cycle.
- A requester whose *_req stays high after its end pulse is re-arbitrated normally and may be granted again after one S_ARBIT cycle.
- Simultaneous end pulse and new request: bus returns to S_ARBIT first; minimum one idle (NOP) cycle between owners.
- End pulses from non-owning stages are ignored.
- RST asserted mid-operation: everything returns to reset values immediately, including cke 0 and S_INIT. Init must rerun.

## Structure
- Shared package sdram_pkg:
  - command constants NOP=4'b0111, PRE=4'b0010, ACT=4'b0011, AREF=4'b0001, WR=4'b0100, RD=4'b0101
  - state encodings
  - ADDR_W/BANK_W defaults
- One sub-module is natural: sdram_cmd_mux, a combinational 4-way source select. The output register and FSM stay in sdram_arbit.

## Test plan
- Reset release with flag_init_end = 0, init_cmd = 4'b0010: cke = 1 after one cycle; pins follow init_cmd with 1-cycle lag; no *_en pulses.
- flag_init_end = 1, then wr_req = 1: S_ARBIT for one cycle, then wr_en high for one cycle; wr_cmd = ACT, wr_addr = 12'h001 appear on the pins next cycle; flag_wr_end returns the pins to NOP.
- wr_req and rd_req held high continuously: grants alternate wr, rd, wr, rd; exactly one pulse per grant.
- ref_req, wr_req and rd_req all high in S_ARBIT: ref_en granted first; after flag_ref_end, write is granted.
- ref_req raised mid-write: no preemption; after flag_wr_end there is one NOP cycle, then ref_en.
- RST pulsed during S_READ: all outputs at reset values in the same cycle; state S_INIT; rd_en never re-pulses until init completes.
